// File: rtl/if_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: reset vector, fetch FSM encoding and fetch exception bits.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    localparam int          EXC_ADEL_BIT = 0;
    localparam logic [7:0]  EXC_NONE     = 8'h00;

    typedef enum logic [1:0] {
        ST_REQ       = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_HOLD      = 2'd2,
        ST_DISCARD   = 2'd3
    } fetch_state_e;

    function automatic logic [7:0] fetch_exc_vec(input logic adel);
        logic [7:0] v;
        v               = EXC_NONE;
        v[EXC_ADEL_BIT] = adel;
        return v;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus; master is the fetch unit, slave is the memory side.
interface if_fetch_ctrl_if;

    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_addr_ok_i,
        input  inst_data_ok_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_addr_ok_i,
        output inst_data_ok_i,
        output inst_rdata_i
    );

endinterface

// File: rtl/flopr.sv
// Generic register, one-cycle latency; stall_i holds the contents, flush_i clears them (flush wins).
module flopr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (flush_i) begin
            q_o <= '0;
        end else if (!stall_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, zero-cycle data path to IF/ID,
// hold buffer under stall, delay-slot aware redirect, flush with in-flight discard.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [31:0]     flush_pc_i,
    input  logic            branch_i,
    input  logic [31:0]     branch_target_i,
    input  logic            id_is_branch_i,
    if_fetch_ctrl_if.master mem,
    output logic            fetch_valid_o,
    output logic [31:0]     PC_plus4,
    output logic [31:0]     Instruction,
    output logic            is_delayslot,
    output logic [7:0]      fetch_exc
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  tgt_q;
    logic         redir_q;
    logic [31:0]  hold_q;

    // Last delivered IF/ID values, presented while no instruction is valid.
    logic [31:0]  inst_q;
    logic [31:0]  pcp4_q;
    logic         ds_q;
    logic [7:0]   exc_q;

    logic         misaligned;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc_d;
    logic         req;
    logic         valid;
    logic [31:0]  live_inst;
    logic [7:0]   live_exc;
    logic         advance;
    logic         capture;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign pc_plus4   = pc_q + 32'd4;

    // A branch resolving in the same cycle the delay slot is consumed redirects immediately.
    assign next_pc_d = branch_i ? branch_target_i :
                       redir_q  ? tgt_q           : pc_plus4;

    always_comb begin
        req       = 1'b0;
        valid     = 1'b0;
        live_inst = '0;
        live_exc  = EXC_NONE;
        advance   = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (misaligned) begin
                    valid    = 1'b1;
                    live_exc = fetch_exc_vec(1'b1);
                end else begin
                    req = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (mem.inst_data_ok_i) begin
                    valid     = 1'b1;
                    live_inst = mem.inst_rdata_i;
                    advance   = !stall_i;
                    capture   = stall_i;
                end
            end
            ST_HOLD: begin
                valid     = 1'b1;
                live_inst = hold_q;
                advance   = !stall_i;
            end
            ST_DISCARD: begin
                valid = 1'b0;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
        if (!rst_n) begin
            req   = 1'b0;
            valid = 1'b0;
        end
        if (flush_i) begin
            valid   = 1'b0;
            advance = 1'b0;
            capture = 1'b0;
        end
    end

    flopr #(.WIDTH(32)) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (!capture),
        .flush_i (flush_i),
        .d_i     (mem.inst_rdata_i),
        .q_o     (hold_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            redir_q <= 1'b0;
            inst_q  <= '0;
            pcp4_q  <= RESET_VECTOR + 32'd4;
            ds_q    <= 1'b0;
            exc_q   <= EXC_NONE;
        end else begin
            if (valid) begin
                inst_q <= live_inst;
                pcp4_q <= pc_plus4;
                ds_q   <= id_is_branch_i;
                exc_q  <= live_exc;
            end
            if (flush_i) begin
                pc_q    <= flush_pc_i;
                redir_q <= 1'b0;
                unique case (state_q)
                    ST_REQ:       state_q <= (req && mem.inst_addr_ok_i) ? ST_DISCARD : ST_REQ;
                    ST_WAIT_DATA: state_q <= mem.inst_data_ok_i ? ST_REQ : ST_DISCARD;
                    ST_HOLD:      state_q <= ST_REQ;
                    ST_DISCARD:   state_q <= mem.inst_data_ok_i ? ST_REQ : ST_DISCARD;
                    default:      state_q <= ST_REQ;
                endcase
            end else begin
                if (advance) begin
                    pc_q    <= next_pc_d;
                    redir_q <= 1'b0;
                end else if (branch_i) begin
                    redir_q <= 1'b1;
                    tgt_q   <= branch_target_i;
                end
                unique case (state_q)
                    ST_REQ: begin
                        if (req && mem.inst_addr_ok_i) state_q <= ST_WAIT_DATA;
                    end
                    ST_WAIT_DATA: begin
                        if (mem.inst_data_ok_i) state_q <= stall_i ? ST_HOLD : ST_REQ;
                    end
                    ST_HOLD: begin
                        if (!stall_i) state_q <= ST_REQ;
                    end
                    ST_DISCARD: begin
                        if (mem.inst_data_ok_i) state_q <= ST_REQ;
                    end
                    default: state_q <= ST_REQ;
                endcase
            end
        end
    end

    assign mem.inst_req_o  = req;
    assign mem.inst_addr_o = pc_q;
    assign fetch_valid_o   = valid;
    assign Instruction     = valid ? live_inst      : inst_q;
    assign PC_plus4        = valid ? pc_plus4       : pcp4_q;
    assign is_delayslot    = valid ? id_is_branch_i : ds_q;
    assign fetch_exc       = valid ? live_exc       : exc_q;

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Port clk  in  1  clock; all state SHALL update on its rising edge.
REQ-002 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-003 Port stall_i  in  1  downstream IF/ID stall; the delivered instruction is not consumed this cycle.
REQ-004 Port flush_i  in  1  exception/eret redirect; flush_pc_i  in  32  redirect target.
REQ-005 Port branch_i  in  1  taken branch/jump resolved in ID; branch_target_i  in  32  its target.
REQ-006 Port id_is_branch_i  in  1  the instruction currently in ID is a branch/jump.
REQ-007 Port inst_req_o  out  1  memory request; inst_addr_o  out  32  request address.
REQ-008 Port inst_addr_ok_i  in  1  address accepted; inst_data_ok_i  in  1  data returned; inst_rdata_i  in  32  returned word.
REQ-009 Port fetch_valid_o  out  1  instruction outputs valid this cycle; 0 means the IF/ID stage receives a bubble.
REQ-010 Port PC_plus4  out  32, Instruction  out  32, is_delayslot  out  1, fetch_exc  out  8: the data inputs of the IF/ID pipeline register.

Function
REQ-011 At most one memory request SHALL be outstanding.
REQ-012 State machine states: REQ, WAIT_DATA, HOLD, DISCARD.
REQ-013 REQ: inst_req_o=1, inst_addr_o=pc; on inst_addr_ok_i -> WAIT_DATA; otherwise stay in REQ.
REQ-014 WAIT_DATA: on inst_data_ok_i, Instruction=inst_rdata_i and fetch_valid_o=1 in that same cycle (zero-cycle data path); if stall_i=0 -> REQ with the next pc; if stall_i=1 -> capture the word into the hold buffer and go to HOLD.
REQ-015 HOLD: fetch_valid_o=1 and Instruction taken from the hold buffer; stay in HOLD while stall_i=1; on stall_i=0 -> REQ with the next pc.
REQ-016 DISCARD: inst_req_o=0, fetch_valid_o=0; on inst_data_ok_i, drop the data -> REQ.
REQ-017 PC_plus4 SHALL equal pc+4 of the delivered instruction, with modulo 2^32 wrap.
REQ-018 The next pc after a delivery SHALL be pending target if redirect_pending=1 (then clear the flag), else pc+4.
REQ-019 branch_i=1 SHALL set redirect_pending and latch branch_target_i, so that the delay slot currently being fetched is still delivered and the following fetch goes to the target.
REQ-020 is_delayslot SHALL equal id_is_branch_i in the delivery cycle.
REQ-021 Misaligned pc (pc[1:0]!=0) in REQ: no request is issued; fetch_valid_o=1, Instruction=0, fetch_exc=8'h01 (bit0 = AdEL-fetch), PC_plus4=pc+4; then the unit holds that pc until a flush arrives.
REQ-022 fetch_exc SHALL be 8'h00 for every aligned fetch.
REQ-023 flush_i has the highest priority: pc<=flush_pc_i, redirect_pending cleared, fetch_valid_o=0 that cycle.
REQ-024 Flush behaviour by state:
  - In REQ, or in REQ with addr_ok coincident: REQ with the new pc, or DISCARD if addr_ok was coincident.
  - In WAIT_DATA without data_ok: DISCARD.
  - In WAIT_DATA with data_ok, or in HOLD: REQ.
REQ-025 branch_i and flush_i in the same cycle: the flush wins and the branch is ignored.
REQ-026 When fetch_valid_o=0, the Instruction, PC_plus4, is_delayslot and fetch_exc values are don't-care but stable (held).

Reset
REQ-027 While rst_n=0:
  - state=REQ, pc=32'hBFC00000, redirect_pending=0, hold buffer=0.
  - inst_req_o=0, fetch_valid_o=0, Instruction=0, PC_plus4=32'hBFC00004, is_delayslot=0, fetch_exc=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; a data_ok arriving after reset release without a matching request SHALL be ignored.
REQ-029 The first request SHALL be issued in the first cycle after rst_n deasserts.

Structure
REQ-030 The reset vector, the state encoding and the fetch_exc bit positions SHALL live in the shared CPU definitions package.
REQ-031 The hold buffer SHALL reuse the existing flopr register sub-module (stall/flush-capable), instantiated once as a 32-bit register.

Verification
REQ-032 Reset release, addr_ok immediate, data_ok one cycle later with 32'h24020001 -> inst_addr_o=BFC00000, Instruction=24020001, PC_plus4=BFC00004, fetch_valid_o=1.
REQ-033 data_ok with stall_i=1 for 3 cycles -> HOLD; Instruction is held for 3 cycles, no new request is issued, the next address is BFC00004.
REQ-034 branch_i with target 8000_0100 while fetching BFC00008 and id_is_branch_i=1 -> BFC00008 is delivered with is_delayslot=1, and the next inst_addr_o is 80000100.
REQ-035 flush_i with flush_pc_i=BFC00380 in WAIT_DATA -> the returned word is dropped (fetch_valid_o=0), and the next request is to BFC00380.
REQ-036 flush_pc_i=8000_0002 -> no request is issued; fetch_valid_o=1, fetch_exc=8'h01, Instruction=0.
REQ-037 rst_n pulsed low in WAIT_DATA, then a stale data_ok -> it is ignored, and the first delivered PC_plus4 is BFC00004.
